// File: rtl/mm_result_collector.sv
// mm_result_collector
// -------------------
// Downstream stage of the matrix-multiply engine. It captures the serial
// result stream (one signed element per valid cycle, with a row-end marker)
// into a local buffer and tracks the result dimensions. It flags rows whose
// length differs from the first row. It then replays the buffered matrix
// over a valid/ready handshake with row and frame markers. A one-cycle
// frame_done pulse carries the held status:
// rows, cols, error code and error-pattern code.
//
// Optional feature (compile-time macro RESULT_CHECKSUM_EN):
//   defined     -> 16-bit running sum of sign-extended replayed elements,
//                  published on checksum at frame_done and then held
//   not defined -> checksum is tied to 0 and no accumulator is built
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   in_valid       producer element strobe
//   in_data        signed result element
//   in_row_last    element is the last of its row (qualified by in_valid)
//   in_done        producer finished the current matrix (pulse)
//   in_illegal     producer rejected the operand pair (pulse)
//   in_ep          producer error-pattern code, sampled with in_illegal
//   out_valid      replay element available
//   out_ready      consumer accepts element
//   out_data       replay element
//   out_row_last   out_data is the last element of a row
//   out_frame_last out_data is the last element of the matrix
//   frame_done     one-cycle status pulse
//   res_rows       result row count (held)
//   res_cols       result column count (held)
//   err_code       [0] ragged, [1] overflow, [2] overrun, [3] illegal (held)
//   err_ep         in_ep captured on in_illegal (held)
//   busy           high while collecting, draining or reporting
//   checksum       replay checksum (see optional feature)

module mm_result_collector #(
  parameter int DATA_W    = 12,
  parameter int MAX_ELEMS = 36,
  parameter int ADDR_W    = 6,
  parameter int DIM_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_row_last,
  input  logic              in_done,
  input  logic              in_illegal,
  input  logic [1:0]        in_ep,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_row_last,
  output logic              out_frame_last,
  output logic              frame_done,
  output logic [DIM_W-1:0]  res_rows,
  output logic [DIM_W-1:0]  res_cols,
  output logic [3:0]        err_code,
  output logic [1:0]        err_ep,
  output logic              busy,
  output logic [15:0]       checksum
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nxt;

  // Result buffer; contents are never reset.
  logic [DATA_W-1:0] mem [MAX_ELEMS];

  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt, rd_ptr, last_idx;
  logic [DIM_W-1:0]  col_cnt, col_nxt;
  logic [DIM_W-1:0]  row_cnt, row_nxt;
  logic [DIM_W-1:0]  width, width_nxt;
  logic [DIM_W-1:0]  rd_col;
  logic              ragged, ragged_nxt;
  logic              ovf, ovf_nxt;
  logic              overrun;

  logic collecting;
  logic take_elem;
  logic elem_fits;
  logic illegal_evt;
  logic overrun_evt;
  logic frame_last;
  logic xfer;
  logic enter_done;

  assign collecting  = (state == IDLE) || (state == COLLECT);
  // in_illegal wins over a simultaneous element, which is discarded.
  assign take_elem   = collecting && in_valid && !in_illegal;
  assign elem_fits   = wr_ptr < ADDR_W'(MAX_ELEMS);
  assign illegal_evt = collecting && in_illegal;
  // Any producer activity while replaying or reporting is an overrun.
  assign overrun_evt = ((state == DRAIN) || (state == DONE)) &&
                       (in_valid || in_done || in_illegal);

  // Dimension tracking and ragged/overflow detection for the next cycle.
  // An element that does not fit is dropped, but it still counts toward
  // the row length so the ragged check sees the true stream shape. An
  // in_done that arrives mid-row closes that partial row as if it had a
  // row-end marker, after any element captured in the same cycle.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    col_nxt    = col_cnt;
    row_nxt    = row_cnt;
    width_nxt  = width;
    ragged_nxt = ragged;
    ovf_nxt    = ovf;

    if (take_elem) begin
      if (elem_fits) begin
        wr_ptr_nxt = wr_ptr + ADDR_W'(1);
      end else begin
        ovf_nxt = 1'b1;
      end
      if (in_row_last) begin
        row_nxt = row_cnt + DIM_W'(1);
        col_nxt = '0;
        if (row_cnt == '0) begin
          width_nxt = col_cnt + DIM_W'(1);
        end else if ((col_cnt + DIM_W'(1)) != width) begin
          ragged_nxt = 1'b1;
        end
      end else begin
        col_nxt = col_cnt + DIM_W'(1);
      end
    end

    if (collecting && in_done && !in_illegal && (col_nxt != '0)) begin
      if (row_nxt == '0) begin
        width_nxt = col_nxt;
      end else if (col_nxt != width_nxt) begin
        ragged_nxt = 1'b1;
      end
      row_nxt = row_nxt + DIM_W'(1);
      col_nxt = '0;
    end
  end

  // Next-state logic. An element arriving together with in_done in IDLE
  // is captured and the one-element frame goes straight to replay.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (in_illegal) begin
          state_nxt = DONE;
        end else if (in_valid) begin
          state_nxt = in_done ? DRAIN : COLLECT;
        end else if (in_done) begin
          state_nxt = DONE;
        end
      end
      COLLECT: begin
        if (in_illegal) begin
          state_nxt = DONE;
        end else if (in_done) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer && frame_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Collection counters, replay pointers and sticky error flags. Leaving
  // DONE clears everything for the next frame, except that an overrun
  // seen during the DONE cycle itself is carried to the next report.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_col  <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
      width   <= '0;
      ragged  <= 1'b0;
      ovf     <= 1'b0;
      overrun <= 1'b0;
    end else if (state == DONE) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_col  <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
      width   <= '0;
      ragged  <= 1'b0;
      ovf     <= 1'b0;
      overrun <= overrun_evt;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      col_cnt <= col_nxt;
      row_cnt <= row_nxt;
      width   <= width_nxt;
      ragged  <= ragged_nxt;
      ovf     <= ovf_nxt;
      overrun <= overrun | overrun_evt;
      if (xfer) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
        rd_col <= out_row_last ? '0 : (rd_col + DIM_W'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take_elem && elem_fits) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Status is published on entry to DONE, so it is valid during the
  // frame_done cycle and held until the next one. A rejected frame
  // reports zero dimensions. An overrun in this same cycle is folded in.
  assign enter_done = (state != DONE) && (state_nxt == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_rows <= '0;
      res_cols <= '0;
      err_code <= '0;
      err_ep   <= '0;
    end else if (enter_done) begin
      res_rows <= illegal_evt ? '0 : row_cnt;
      res_cols <= illegal_evt ? '0 : width;
      err_code <= {illegal_evt, overrun | overrun_evt, ovf, ragged};
      err_ep   <= illegal_evt ? in_ep : 2'b00;
    end
  end

  // wr_ptr never exceeds MAX_ELEMS, so the last buffered index is simply
  // wr_ptr-1 during replay.
  assign last_idx       = wr_ptr - ADDR_W'(1);
  assign frame_last     = (rd_ptr == last_idx);
  assign out_valid      = (state == DRAIN);
  assign out_data       = out_valid ? mem[rd_ptr] : '0;
  assign out_row_last   = out_valid && (frame_last || (rd_col == (width - DIM_W'(1))));
  assign out_frame_last = out_valid && frame_last;
  assign xfer           = out_valid && out_ready;
  assign frame_done     = (state == DONE);
  assign busy           = (state != IDLE);

`ifdef RESULT_CHECKSUM_EN
  logic [15:0] acc;
  logic [15:0] data_ext;

  assign data_ext = 16'(signed'(out_data));

  // The accumulator restarts on entry to DRAIN. On the final transfer the
  // element being accepted is added directly into the published value.
  // Frames that never replay publish zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      checksum <= '0;
    end else begin
      if ((state != DRAIN) && (state_nxt == DRAIN)) begin
        acc <= '0;
      end else if (xfer) begin
        acc <= acc + data_ext;
      end
      if (enter_done) begin
        checksum <= (state == DRAIN) ? (acc + data_ext) : 16'h0000;
      end
    end
  end
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_mm_result_collector.sv
// Testbench for mm_result_collector: directed frames plus randomized frames.
// Results are compared against a frame-level reference model built from
// the row lengths and element list of each frame.

module tb_mm_result_collector;

  localparam int DATA_W    = 12;
  localparam int MAX_ELEMS = 36;
  localparam int ADDR_W    = 6;
  localparam int DIM_W     = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_row_last = 1'b0;
  logic              in_done = 1'b0;
  logic              in_illegal = 1'b0;
  logic [1:0]        in_ep = 2'b00;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_row_last;
  logic              out_frame_last;
  logic              frame_done;
  logic [DIM_W-1:0]  res_rows;
  logic [DIM_W-1:0]  res_cols;
  logic [3:0]        err_code;
  logic [1:0]        err_ep;
  logic              busy;
  logic [15:0]       checksum;

  mm_result_collector #(
    .DATA_W(DATA_W), .MAX_ELEMS(MAX_ELEMS), .ADDR_W(ADDR_W), .DIM_W(DIM_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_row_last(in_row_last),
    .in_done(in_done), .in_illegal(in_illegal), .in_ep(in_ep),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row_last(out_row_last), .out_frame_last(out_frame_last),
    .frame_done(frame_done), .res_rows(res_rows), .res_cols(res_cols),
    .err_code(err_code), .err_ep(err_ep), .busy(busy), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Frame description: element values and row lengths, in stream order.
  logic [DATA_W-1:0] stim_q[$];
  int                row_len[$];

  // Reference model results for the current frame.
  int          exp_n;
  int          exp_rows;
  int          exp_cols;
  logic [3:0]  exp_err;
  logic [31:0] exp_sum;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idleInputs();
    in_valid    = 1'b0;
    in_row_last = 1'b0;
    in_done     = 1'b0;
    in_illegal  = 1'b0;
    in_ep       = 2'b00;
    in_data     = '0;
  endtask

  task automatic fillRandom(input int n);
    for (int i = 0; i < n; i++) stim_q.push_back(12'($urandom));
  endtask

  // Whole-frame view: every row (partial or not) is compared against the
  // first row; only the first MAX_ELEMS elements survive.
  task automatic computeModel(input bit overrun);
    int total;
    int sum;
    total    = 0;
    sum      = 0;
    exp_err  = 4'b0000;
    exp_rows = row_len.size();
    exp_cols = (exp_rows > 0) ? row_len[0] : 0;
    foreach (row_len[r]) begin
      total += row_len[r];
      if (row_len[r] != exp_cols) exp_err[0] = 1'b1;
    end
    exp_n = (total > MAX_ELEMS) ? MAX_ELEMS : total;
    if (total > MAX_ELEMS) exp_err[1] = 1'b1;
    exp_err[2] = overrun;
    for (int i = 0; i < exp_n; i++) sum += int'($signed(stim_q[i]));
`ifdef RESULT_CHECKSUM_EN
    exp_sum = 32'(sum) & 32'h0000_FFFF;
`else
    exp_sum = 32'h0;
`endif
  endtask

  // Streams the frame one element per cycle, then in_done (either on the
  // last element or alone in the following cycle).
  task automatic applyStimulus(input bit done_with_last, input bit last_partial);
    int k;
    int total;
    k = 0;
    total = 0;
    foreach (row_len[r]) total += row_len[r];
    foreach (row_len[r]) begin
      for (int j = 0; j < row_len[r]; j++) begin
        @(negedge clk);
        in_valid    = 1'b1;
        in_data     = stim_q[k];
        in_row_last = (j == row_len[r] - 1) && !(last_partial && (r == row_len.size() - 1));
        k++;
        in_done     = done_with_last && (k == total);
      end
    end
    if (!done_with_last) begin
      @(negedge clk);
      idleInputs();
      in_done = 1'b1;
    end
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,..., 2: random ready.
  task automatic drainAndCheck(input int mode, input int inject_cyc, input string name);
    int k;
    bit seen;
    k = 0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
      @(negedge clk);
      idleInputs();
      if (cyc == inject_cyc) begin
        in_valid = 1'b1;
        in_data  = 12'h5A5;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 3) == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (frame_done) begin
        seen = 1'b1;
        checkOutput({name, " transfers"}, k, exp_n);
        checkOutput({name, " rows"}, res_rows, exp_rows);
        checkOutput({name, " cols"}, res_cols, exp_cols);
        checkOutput({name, " err_code"}, err_code, exp_err);
        checkOutput({name, " err_ep"}, err_ep, 0);
        checkOutput({name, " checksum"}, checksum, exp_sum);
      end else if (out_valid) begin
        if (k >= exp_n) begin
          checkOutput({name, " extra element"}, k, exp_n - 1);
        end else begin
          checkOutput({name, " data"}, out_data, stim_q[k]);
          checkOutput({name, " row_last"}, out_row_last,
                      ((k % exp_cols) == exp_cols - 1) || (k == exp_n - 1));
          checkOutput({name, " frame_last"}, out_frame_last, (k == exp_n - 1));
          if (out_ready) k++;
        end
      end
    end
    checkOutput({name, " frame_done seen"}, seen, 1);
    @(negedge clk);
    idleInputs();
    out_ready = 1'b1;
    #1;
    checkOutput({name, " idle after done"}, {frame_done, busy}, 0);
  endtask

  initial begin
    $display("[TB] start");

    // Reset state
    idleInputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset frame_done", frame_done, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset status", {res_rows, res_cols, err_code, err_ep}, 0);
    checkOutput("reset checksum", checksum, 0);
    checkOutput("reset out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b1;

    // 2x3 frame 1,2,3 / -4,5,-6
    stim_q = '{12'h001, 12'h002, 12'h003, 12'hFFC, 12'h005, 12'hFFA};
    row_len = '{3, 3};
    computeModel(1'b0);
    applyStimulus(1'b0, 1'b0);
    drainAndCheck(0, -1, "2x3");

    // Empty frame: in_done alone
    @(negedge clk);
    in_done = 1'b1;
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("empty frame_done", frame_done, 1);
    checkOutput("empty status", {res_rows, res_cols, err_code}, 0);

    // Ragged: rows of 3 then 2
    stim_q.delete();
    fillRandom(5);
    row_len = '{3, 2};
    computeModel(1'b0);
    applyStimulus(1'b0, 1'b0);
    drainAndCheck(0, -1, "ragged");

    // Illegal after two elements
    stim_q.delete();
    fillRandom(2);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = stim_q[0];
    @(negedge clk);
    in_data  = stim_q[1];
    @(negedge clk);
    idleInputs();
    in_illegal = 1'b1;
    in_ep      = 2'b10;
    #1;
    checkOutput("illegal no out_valid", out_valid, 0);
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("illegal frame_done", frame_done, 1);
    checkOutput("illegal out_valid", out_valid, 0);
    checkOutput("illegal err_code", err_code, 4'b1000);
    checkOutput("illegal err_ep", err_ep, 2'b10);
    checkOutput("illegal dims", {res_rows, res_cols}, 0);
    checkOutput("illegal checksum", checksum, 0);
    @(negedge clk);
    #1;
    checkOutput("illegal pulse width", {frame_done, busy}, 0);

    // 2x2 with out_ready stalls
    stim_q.delete();
    fillRandom(4);
    row_len = '{2, 2};
    computeModel(1'b0);
    applyStimulus(1'b0, 1'b0);
    drainAndCheck(1, -1, "stall");

    // 37 elements: overflow, partial last row, plus overrun during replay
    stim_q.delete();
    fillRandom(37);
    row_len = '{6, 6, 6, 6, 6, 6, 1};
    computeModel(1'b1);
    applyStimulus(1'b0, 1'b1);
    drainAndCheck(0, 3, "overflow");

    // Randomized frames
    for (int f = 0; f < 5; f++) begin
      int nr;
      int nc;
      int total;
      bit dwl;
      nr = $urandom_range(1, 6);
      nc = $urandom_range(1, 6);
      row_len.delete();
      total = 0;
      for (int r = 0; r < nr; r++) begin
        int len;
        len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : nc;
        row_len.push_back(len);
        total += len;
      end
      stim_q.delete();
      fillRandom(total);
      computeModel(1'b0);
      dwl = (total > 1) && ($urandom_range(0, 1) == 1);
      applyStimulus(dwl, 1'b0);
      drainAndCheck(2, -1, $sformatf("rand%0d", f));
    end

    // Reset in the middle of replay
    stim_q.delete();
    fillRandom(4);
    row_len = '{2, 2};
    computeModel(1'b0);
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    idleInputs();
    out_ready = 1'b1;
    #1;
    checkOutput("mid-drain out_valid", out_valid, 1);
    rst = 1'b0;
    #1;
    checkOutput("async reset out_valid", out_valid, 0);
    checkOutput("async reset busy", busy, 0);
    checkOutput("async reset status", {res_rows, res_cols, err_code, err_ep}, 0);
    checkOutput("async reset out_data", out_data, 0);
    @(negedge clk);
    #1;
    checkOutput("aborted no frame_done", frame_done, 0);
    rst = 1'b1;

    // 1x1 frame, value -7
    stim_q = '{12'hFF9};
    row_len = '{1};
    computeModel(1'b0);
    applyStimulus(1'b0, 1'b0);
    drainAndCheck(0, -1, "1x1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
